pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage 64-bit RISC-V pipeline (IF/ID/EX/MEM/WB, forwarding already present). It detects load-use hazards and inserts one bubble. It squashes wrong-path instructions when a branch resolves taken in MEM. It freezes the whole pipeline while a multi-cycle data memory has not answered, with a timeout trap. It drives every PC/pipeline-register write-enable and flush.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encodings, the hard-wired zero register index and the default
// data-memory timeout.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_TRAP      = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Writes to x0 never create a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  output logic                  hazard_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  assign rs1_hit  = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
  assign rs2_hit  = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
  assign rd_live  = (ex_rd_i != REG_ADDR_W'(REG_ZERO));
  assign hazard_o = ex_mem_read_i && rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Handles load-use
// bubbles, taken-branch squashes in MEM, and a full freeze while the data
// memory is busy, trapping if it never answers.
// Optional build macro HAZ_PERF_CNT_EN adds 32-bit event counters
// (perf_load_use, perf_branch_flush, perf_dmem_wait).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int WAIT_CNT_W   = 8,
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  ex_mem_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_bubble,
  output logic                  dmem_timeout,
  output logic [1:0]            ctrl_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_load_use,
  output logic [31:0]           perf_branch_flush,
  output logic [31:0]           perf_dmem_wait
`endif
);

  ctrl_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;

  logic load_use;
  logic mem_wait;
  logic apply_lu, apply_br, apply_wait;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .ex_mem_read_i (ex_MemRead),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .hazard_o      (load_use)
  );

  // A memory access that is not answered this cycle holds the whole pipe.
  assign mem_wait = mem_access && !dmem_ready;

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state: TRAP is terminal; otherwise an unanswered access either
  // keeps waiting or, once the counter has reached the limit, traps. The
  // counter stops at the limit so it can never wrap.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (state_q != ST_TRAP) begin
      if (mem_wait) begin
        if (wait_cnt_q == WAIT_CNT_W'(DMEM_TIMEOUT)) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end else begin
          state_d    = ST_DMEM_WAIT;
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end else begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    end
  end

  // Outputs by priority: trap freeze, memory freeze, branch squash,
  // load-use bubble. During reset everything sits at the free-running values.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    apply_lu      = 1'b0;
    apply_br      = 1'b0;
    apply_wait    = 1'b0;
    if (reset) begin
      // free-running defaults
    end else if (state_q == ST_TRAP || mem_wait) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
      apply_wait    = (state_q != ST_TRAP);
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      apply_br     = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      apply_lu    = 1'b1;
    end
  end

  assign dmem_timeout = timeout_q && !reset;
  assign ctrl_state   = reset ? ST_RUN : state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_br_q, perf_wait_q;

  // Event counters, one tick per cycle the corresponding action is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lu_q   <= '0;
      perf_br_q   <= '0;
      perf_wait_q <= '0;
    end else begin
      if (apply_lu)   perf_lu_q   <= perf_lu_q + 32'd1;
      if (apply_br)   perf_br_q   <= perf_br_q + 32'd1;
      if (apply_wait) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_load_use     = perf_lu_q;
  assign perf_branch_flush = perf_br_q;
  assign perf_dmem_wait    = perf_wait_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed stimulus, a cycle model of the
// sequencing rules checked every negative edge, plus literal spot checks.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk, reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_MemRead;
  logic       branch_taken, mem_access, dmem_ready;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble;
  logic       dmem_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_load_use, perf_branch_flush, perf_dmem_wait;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .WAIT_CNT_W(8), .DMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
    .dmem_timeout(dmem_timeout), .ctrl_state(ctrl_state)
`ifdef HAZ_PERF_CNT_EN
    , .perf_load_use(perf_load_use), .perf_branch_flush(perf_branch_flush),
    .perf_dmem_wait(perf_dmem_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0=running, 1=waiting on memory, 2=trapped; consecutive
  // unanswered cycles seen so far; sticky trap flag.
  int m_mode   = 0;
  int m_stalls = 0;
  bit m_flag   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= 0; m_stalls <= 0; m_flag <= 1'b0;
    end else if (m_mode != 2) begin
      if (mem_access && !dmem_ready) begin
        // the (TMO+1)-th consecutive unanswered cycle traps
        if (m_stalls + 1 > TMO) begin
          m_mode <= 2; m_flag <= 1'b1;
        end else begin
          m_mode <= 1; m_stalls <= m_stalls + 1;
        end
      end else begin
        m_mode <= 0; m_stalls <= 0;
      end
    end
  end

  function automatic logic [10:0] model_out();
    logic pw, ifw, idw, exw, f1, f2, f3, bub, lu;
    pw = 1; ifw = 1; idw = 1; exw = 1; f1 = 0; f2 = 0; f3 = 0; bub = 0;
    if (reset) return {4'b1111, 4'b0000, 1'b0, 2'd0};
    lu = ex_MemRead && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    if (m_mode == 2 || (mem_access && !dmem_ready)) begin
      pw = 0; ifw = 0; idw = 0; exw = 0; bub = 1;
    end else if (branch_taken) begin
      f1 = 1; f2 = 1; f3 = 1;
    end else if (lu) begin
      pw = 0; ifw = 0; f2 = 1;
    end
    return {pw, ifw, idw, exw, f1, f2, f3, bub, m_flag, 2'(m_mode)};
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [10:0] exp_v, act_v;
    exp_v = model_out();
    act_v = {pc_write, if_id_write, id_ex_write, ex_mem_write,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
             dmem_timeout, ctrl_state};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got=%b expected=%b", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_MemRead = 0; branch_taken = 0; mem_access = 0; dmem_ready = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    ex_MemRead = 1; ex_rd = rd; id_rs1 = r1; id_uses_rs1 = u1;
    id_rs2 = r2; id_uses_rs2 = u2;
  endtask

  initial begin
    idle();
    // reset with a pending unanswered access: outputs stay free-running
    reset = 1; mem_access = 1;
    #1;
    chk("reset_pc_write", 32'(pc_write), 1);
    chk("reset_bubble", 32'(mem_wb_bubble), 0);
    tick(); tick();
    reset = 0; idle(); #1;
    chk("post_reset_state", 32'(ctrl_state), 0);
    chk("post_reset_timeout", 32'(dmem_timeout), 0);

    // ld x5 in EX, add x6,x5,x7 in ID
    set_lu(5, 5, 1, 7, 1); #1;
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_if_id_write", 32'(if_id_write), 0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
    chk("lu_id_ex_write", 32'(id_ex_write), 1);
    tick(); idle(); id_rs1 = 5; id_uses_rs1 = 1; #1;
    chk("lu_next_pc_write", 32'(pc_write), 1);
    chk("lu_next_flush", 32'(id_ex_flush), 0);
    tick();
    set_lu(0, 0, 1, 0, 1); #1;                 // x0 load never stalls
    chk("lu_x0_pc_write", 32'(pc_write), 1);
    tick(); set_lu(7, 3, 1, 7, 1); #1;         // rs2 match
    chk("lu_rs2_if_id_write", 32'(if_id_write), 0);
    tick(); set_lu(7, 3, 1, 7, 0); #1;         // rs2 not read
    chk("lu_rs2_unused_pc", 32'(pc_write), 1);
    tick(); idle();

    // branch alone, then branch with a simultaneous load-use
    branch_taken = 1; #1;
    chk("br_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'h7);
    chk("br_pc_write", 32'(pc_write), 1);
    tick(); idle(); #1;
    chk("br_after_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 0);
    tick(); set_lu(5, 5, 1, 0, 0); branch_taken = 1; #1;
    chk("br_lu_pc_write", 32'(pc_write), 1);
    chk("br_lu_if_id_write", 32'(if_id_write), 1);
    tick(); idle();

    // three-cycle memory wait, branch ignored while frozen
    mem_access = 1; dmem_ready = 0; branch_taken = 1; #1;
    chk("mw_pc_write", 32'(pc_write), 0);
    chk("mw_bubble", 32'(mem_wb_bubble), 1);
    chk("mw_branch_suppressed", 32'(if_id_flush), 0);
    tick(); branch_taken = 0; #1;
    chk("mw_state", 32'(ctrl_state), 1);
    tick(); tick(); dmem_ready = 1; #1;
    chk("mw_exit_pc_write", 32'(pc_write), 1);
    chk("mw_exit_bubble", 32'(mem_wb_bubble), 0);
    tick(); idle(); #1;
    chk("mw_back_run", 32'(ctrl_state), 0);
    // zero-wait access stays in RUN
    mem_access = 1; dmem_ready = 1; tick(); #1;
    chk("zero_wait_state", 32'(ctrl_state), 0);

    // timeout: counter starts from zero again, trap after the 5th wait cycle
    mem_access = 1; dmem_ready = 0;
    repeat (TMO) tick();
    chk("tmo_not_yet", 32'(ctrl_state), 1);
    tick();
    chk("tmo_state", 32'(ctrl_state), 2);
    chk("tmo_flag", 32'(dmem_timeout), 1);
    idle(); branch_taken = 1; dmem_ready = 1; tick(); tick();
    chk("trap_hold_state", 32'(ctrl_state), 2);
    chk("trap_hold_pc", 32'(pc_write), 0);
    chk("trap_hold_flush", 32'(if_id_flush), 0);
    chk("trap_hold_flag", 32'(dmem_timeout), 1);
    reset = 1; #1;
    chk("trap_reset_pc", 32'(pc_write), 1);
    tick(); reset = 0; idle(); #1;
    chk("trap_reset_state", 32'(ctrl_state), 0);
    chk("trap_reset_flag", 32'(dmem_timeout), 0);

    // reset in the middle of a wait clears the counter
    mem_access = 1; dmem_ready = 0; tick(); tick();
    reset = 1; tick(); reset = 0; #1;
    chk("midwait_reset_state", 32'(ctrl_state), 0);
    repeat (TMO) tick();
    chk("midwait_count_fresh", 32'(ctrl_state), 1);
    tick();
    chk("midwait_trap", 32'(ctrl_state), 2);
    reset = 1; tick(); reset = 0; idle(); tick();

`ifdef HAZ_PERF_CNT_EN
    set_lu(5, 5, 1, 0, 0); tick(); idle(); tick();
    set_lu(9, 0, 0, 9, 1); tick(); idle(); tick();
    branch_taken = 1; tick(); idle();
    mem_access = 1; dmem_ready = 0; tick(); tick(); tick();
    dmem_ready = 1; tick(); idle(); #1;
    chk("perf_load_use", perf_load_use, 2);
    chk("perf_branch", perf_branch_flush, 1);
    chk("perf_dmem_wait", perf_dmem_wait, 3);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
